if_id_fetch_stage: RTL

- Fetch stage: holds the PC and drives the instruction-memory request. Owns the IF/ID pipeline register, whose outputs feed decode and the hazard unit's RA/RB/RC decode path.
- Consumes the hazard unit's PC-load and IF/ID-load enables (stall) and the EX-stage branch redirect (flush).
- Tolerates multi-cycle instruction memory via a req/ready handshake, a one-entry hold buffer and a redirect-drain state.

---
 rtl/if_id_fetch_stage.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/if_id_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : if_id_fetch_stage
// Purpose  : PC / instruction fetch with req-ready memory handshake, stall hold
//            buffer, branch redirect drain and IF/ID pipeline register.
//            Optional perf counters when FETCH_PERF_EN is defined.
// Revision : 1.0
// ============================================================================
module if_id_fetch_stage #(
    parameter int                ADDR_W   = 32,
    parameter int                INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                PC_STEP  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pc_ld,
    input  logic               if_id_ld,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ready,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] id_instr,
    output logic [ADDR_W-1:0]  id_pc_next,
    output logic               id_valid,
`ifdef FETCH_PERF_EN
    output logic [15:0]        perf_stall_cnt,
    output logic [15:0]        perf_flush_cnt,
`endif
    output logic               fetch_busy
);

    typedef enum logic [1:0] {
        ST_REQ   = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  pend_q, pend_d;
    logic [INSTR_W-1:0] hold_q, hold_d;
    logic [INSTR_W-1:0] id_instr_q, id_instr_d;
    logic [ADDR_W-1:0]  id_pc_next_q, id_pc_next_d;
    logic               id_valid_q, id_valid_d;
    logic               advance;
    logic [ADDR_W-1:0]  pc_inc;

    assign advance = pc_ld && if_id_ld;
    assign pc_inc  = pc_q + ADDR_W'(PC_STEP);

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pend_d       = pend_q;
        hold_d       = hold_q;
        id_instr_d   = id_instr_q;
        id_pc_next_d = id_pc_next_q;
        id_valid_d   = id_valid_q;

        // A flush always leaves a bubble behind, whatever the stall inputs say.
        if (branch_taken || state_q == ST_DRAIN) begin
            id_instr_d = '0;
            id_valid_d = 1'b0;
        end

        case (state_q)
            ST_REQ: begin
                if (branch_taken) begin
                    if (imem_ready) begin
                        pc_d = branch_target;
                    end else begin
                        pend_d  = branch_target;
                        state_d = ST_DRAIN;
                    end
                end else if (imem_ready && advance) begin
                    id_instr_d   = imem_rdata;
                    id_pc_next_d = pc_inc;
                    id_valid_d   = 1'b1;
                    pc_d         = pc_inc;
                end else if (imem_ready) begin
                    hold_d  = imem_rdata;
                    state_d = ST_HOLD;
                end else if (advance) begin
                    id_instr_d = '0;
                    id_valid_d = 1'b0;
                end
            end
            ST_HOLD: begin
                if (branch_taken) begin
                    pc_d    = branch_target;
                    hold_d  = '0;
                    state_d = ST_REQ;
                end else if (advance) begin
                    id_instr_d   = hold_q;
                    id_pc_next_d = pc_inc;
                    id_valid_d   = 1'b1;
                    pc_d         = pc_inc;
                    hold_d       = '0;
                    state_d      = ST_REQ;
                end
            end
            ST_DRAIN: begin
                if (branch_taken) begin
                    pend_d = branch_target;
                end
                // The in-flight word belongs to the old path; drop it and redirect.
                if (imem_ready) begin
                    pc_d    = branch_taken ? branch_target : pend_q;
                    state_d = ST_REQ;
                end
            end
            default: begin
                state_d = ST_REQ;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_REQ;
            pc_q         <= RESET_PC;
            pend_q       <= '0;
            hold_q       <= '0;
            id_instr_q   <= '0;
            id_pc_next_q <= '0;
            id_valid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pend_q       <= pend_d;
            hold_q       <= hold_d;
            id_instr_q   <= id_instr_d;
            id_pc_next_q <= id_pc_next_d;
            id_valid_q   <= id_valid_d;
        end
    end

    assign imem_req   = rst_n && (state_q != ST_HOLD);
    assign imem_addr  = pc_q;
    assign id_instr   = id_instr_q;
    assign id_pc_next = id_pc_next_q;
    assign id_valid   = id_valid_q;
    assign fetch_busy = (state_q == ST_REQ && !imem_ready) || (state_q == ST_DRAIN);

`ifdef FETCH_PERF_EN
    logic [15:0] perf_stall_q, perf_stall_d;
    logic [15:0] perf_flush_q, perf_flush_d;

    always_comb begin
        perf_stall_d = perf_stall_q;
        perf_flush_d = perf_flush_q;
        if (!advance && !branch_taken && perf_stall_q != 16'hFFFF) begin
            perf_stall_d = perf_stall_q + 16'd1;
        end
        if (branch_taken && perf_flush_q != 16'hFFFF) begin
            perf_flush_d = perf_flush_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    assign perf_stall_cnt = perf_stall_q;
    assign perf_flush_cnt = perf_flush_q;
`endif

endmodule
`default_nettype wire
